// File: rtl/e203_reset_seq_if.sv
// rtl/e203_reset_seq_if.sv - request/ack and domain-reset bundle for the E203 reset sequencer
//
// Purpose: groups the reset sequencer's handshake, request and reset outputs.
//   master : requester/observer side (drives requests, ack, test_mode, cause_clr)
//   slave  : sequencer side (drives quiesce_req, domain resets, rst_cause, seq_busy)
// Signals:
//   test_mode    DFT bypass: resets follow ~rst combinationally
//   sw_rst_req   software full reset request
//   wdg_rst_req  watchdog full reset request
//   dbg_rst_req  debug core-only reset request
//   quiesce_ack  core has drained outstanding bus traffic
//   cause_clr    clears rst_cause
//   quiesce_req  request core to drain
//   rst_aon_n    always-on domain reset, active-low
//   rst_itcm_n   ITCM reset, active-low
//   rst_dtcm_n   DTCM reset, active-low
//   rst_core_n   core reset, active-low
//   rst_cause    sticky cause: [0] sw, [1] wdg, [2] dbg, [3] quiesce timeout
//   seq_busy     sequencer not in RUN
interface e203_reset_seq_if;
  logic       test_mode;
  logic       sw_rst_req;
  logic       wdg_rst_req;
  logic       dbg_rst_req;
  logic       quiesce_ack;
  logic       cause_clr;
  logic       quiesce_req;
  logic       rst_aon_n;
  logic       rst_itcm_n;
  logic       rst_dtcm_n;
  logic       rst_core_n;
  logic [3:0] rst_cause;
  logic       seq_busy;

  modport master (
    output test_mode, sw_rst_req, wdg_rst_req, dbg_rst_req, quiesce_ack, cause_clr,
    input  quiesce_req, rst_aon_n, rst_itcm_n, rst_dtcm_n, rst_core_n, rst_cause, seq_busy
  );

  modport slave (
    input  test_mode, sw_rst_req, wdg_rst_req, dbg_rst_req, quiesce_ack, cause_clr,
    output quiesce_req, rst_aon_n, rst_itcm_n, rst_dtcm_n, rst_core_n, rst_cause, seq_busy
  );
endinterface

// File: rtl/e203_reset_seq.sv
// rtl/e203_reset_seq.sv - ordered domain reset release with quiesce handshake and sticky cause
//
// Purpose: after power-on reset, releases always-on, then ITCM/DTCM, then core.
//   Software/watchdog requests reset ITCM+DTCM+core; debug requests reset the core
//   only. Before asserting resets the core is asked to quiesce (with a timeout).
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  e203_reset_seq_if.slave (requests, quiesce handshake, domain resets, cause, busy)
module e203_reset_seq #(
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int QUIESCE_TIMEOUT = 64,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  e203_reset_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    QUIESCE  = 3'd1,
    HOLD     = 3'd2,
    REL_MEM  = 3'd3,
    REL_CORE = 3'd4
  } state_t;

  typedef enum logic {
    SCOPE_CORE = 1'b0,
    SCOPE_FULL = 1'b1
  } scope_t;

  // The counter holds "edges remaining minus one": a phase ends on the edge
  // that finds it at zero. Reset loads the full HOLD_CYCLES because the first
  // edge with rst low already counts as a HOLD cycle.
  localparam logic [CNT_W-1:0] HOLD_POR  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] QT_LOAD   = CNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  scope_t           scope_q, scope_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cause_q, cause_d, cause_set;
  logic             mem_q, mem_d;
  logic             core_q, core_d;
  logic             qreq_q, qreq_d;
  logic             busy_q, busy_d;
  logic             aon_q;

  logic             full_req;
  logic [3:0]       full_bit;

  // Watchdog outranks software when both arrive together.
  assign full_req = bus.wdg_rst_req | bus.sw_rst_req;
  assign full_bit = bus.wdg_rst_req ? 4'b0010 : 4'b0001;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      scope_q <= SCOPE_FULL;
      cnt_q   <= HOLD_POR;
      cause_q <= 4'b0000;
      mem_q   <= 1'b0;
      core_q  <= 1'b0;
      qreq_q  <= 1'b0;
      busy_q  <= 1'b1;
      aon_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scope_q <= scope_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      mem_q   <= mem_d;
      core_q  <= core_d;
      qreq_q  <= qreq_d;
      busy_q  <= busy_d;
      aon_q   <= 1'b1;
    end
  end

  // Output registers are loaded with the values for the state being entered,
  // so each reset changes on the same edge as the transition that causes it.
  always_comb begin
    state_d   = state_q;
    scope_d   = scope_q;
    cnt_d     = cnt_q;
    cause_set = 4'b0000;
    mem_d     = mem_q;
    core_d    = core_q;
    qreq_d    = 1'b0;
    busy_d    = 1'b1;

    case (state_q)
      RUN: begin
        busy_d = 1'b0;
        if (full_req) begin
          cause_set = full_bit;
          scope_d   = SCOPE_FULL;
        end else if (bus.dbg_rst_req) begin
          cause_set = 4'b0100;
          scope_d   = SCOPE_CORE;
        end
        if (full_req || bus.dbg_rst_req) begin
          state_d = QUIESCE;
          cnt_d   = QT_LOAD;
          qreq_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end

      QUIESCE: begin
        qreq_d = 1'b1;
        // A full request upgrades a pending core-only reset before HOLD entry.
        if (scope_q == SCOPE_CORE && full_req) begin
          cause_set = full_bit;
          scope_d   = SCOPE_FULL;
        end
        if (bus.quiesce_ack || cnt_q == '0) begin
          if (!bus.quiesce_ack) begin
            cause_set[3] = 1'b1;
          end
          state_d = HOLD;
          qreq_d  = 1'b0;
          cnt_d   = HOLD_LOAD;
          core_d  = 1'b0;
          if (scope_d == SCOPE_FULL) begin
            mem_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      HOLD: begin
        if (scope_q == SCOPE_CORE && full_req) begin
          // Late upgrade: memories join the reset and the hold restarts.
          cause_set = full_bit;
          scope_d   = SCOPE_FULL;
          mem_d     = 1'b0;
          cnt_d     = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          if (scope_q == SCOPE_FULL) begin
            mem_d   = 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = REL_MEM;
          end else begin
            state_d = REL_CORE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      REL_MEM: begin
        if (cnt_q == '0) begin
          state_d = REL_CORE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      REL_CORE: begin
        state_d = RUN;
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    // REL_CORE is a zero-length step: the core is released on the same edge
    // that leaves the previous phase, and the sequencer lands directly in RUN.
    if (state_d == REL_CORE) begin
      state_d = RUN;
      core_d  = 1'b1;
      busy_d  = 1'b0;
    end

    // A cause bit being set wins over a simultaneous clear.
    cause_d = (bus.cause_clr ? 4'b0000 : cause_q) | cause_set;
  end

  // DFT bypass: resets follow rst directly and the quiesce request is masked;
  // the sequencer itself keeps running.
  assign bus.rst_aon_n   = bus.test_mode ? ~rst : aon_q;
  assign bus.rst_itcm_n  = bus.test_mode ? ~rst : mem_q;
  assign bus.rst_dtcm_n  = bus.test_mode ? ~rst : mem_q;
  assign bus.rst_core_n  = bus.test_mode ? ~rst : core_q;
  assign bus.quiesce_req = bus.test_mode ? 1'b0 : qreq_q;
  assign bus.rst_cause   = cause_q;
  assign bus.seq_busy    = busy_q;

endmodule
